axis_arp_responder: RTL and testbench
=====================================

# axis_arp_responder

Answers ARP requests addressed to the local IPv4 address directly in hardware. Sits on the logic-clock side of `eth_mac_1g_gmii_fifo`: consumes frames from the MAC `rx_axis_*` stream (32-bit, little-endian lanes, `tkeep`) and emits ARP replies on the MAC `tx_axis_*` stream. This lets the board answer the broadcast ARP requests the GMII bench model generates without firmware involvement.

## Interface
Parameters:
- `REPLY_COUNT_W`, default 16: width of `reply_count`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  logic clock; same clock as the MAC `logic_clk`.
- `resetn`  in  1  asynchronous active-low reset.
- `cfg_mac`  in  48  local MAC; byte 0 is on the wire first and sits in `[47:40]`.
- `cfg_ip`  in  32  local IPv4 address; `[31:24]` is on the wire first.
- `rx_axis_tdata`  in  32  request stream data.
- `rx_axis_tkeep`  in  4  request stream byte enables.
- `rx_axis_tvalid`  in  1  request stream valid.
- `rx_axis_tready`  out  1  request stream ready.
- `rx_axis_tlast`  in  1  request stream end of frame.
- `rx_axis_tuser`  in  1  bad-frame flag; only meaningful on `tlast`.
- `tx_axis_tdata`  out  32  reply stream data.
- `tx_axis_tkeep`  out  4  reply stream byte enables.
- `tx_axis_tvalid`  out  1  reply stream valid.
- `tx_axis_tready`  in  1  reply stream ready.
- `tx_axis_tlast`  out  1  reply stream end of frame.
- `tx_axis_tuser`  out  1  tied to 0.
- `reply_count`  out  `REPLY_COUNT_W`  number of replies fully sent; wraps to 0.

## Operation
Byte mapping:
- Frame byte *i* is in beat *i*/4, lane *i*%4, i.e. `tdata[8*(i%4)+7 -: 8]`.

Request fields (byte offsets):
- 0–5: destination MAC.
- 12–13: ethertype.
- 14–15: htype.
- 16–17: ptype.
- 18: hlen.
- 19: plen.
- 20–21: oper.
- 22–27: sender hardware address (SHA).
- 28–31: sender protocol address (SPA).
- 38–41: target protocol address (TPA).

Accept conditions (all must hold; otherwise the frame is dropped silently):
- Destination MAC is ff:ff:ff:ff:ff:ff or equals `cfg_mac`.
- Ethertype 0x0806, htype 0x0001, ptype 0x0800, hlen 6, plen 4, oper 0x0001.
- TPA equals `cfg_ip`, sampled at beat 10.
- At least 42 bytes received.
- `tuser` = 0 on the `tlast` beat.

States:
- **RX**: counts beats with a counter that saturates at 11, captures SHA and SPA, and accumulates a running "match" flag. Transitions on the `tlast` handshake: to TX if accepted, otherwise stays in RX. Beats past 10 (padding) are ignored.
- **TX**: emits an 11-beat, 42-byte reply. `rx_axis_tready` = 0 throughout. After the beat-10 handshake: increment `reply_count`, return to RX.
- There is no separate drop state; a failed frame simply clears the match flag until `tlast`.

Reply bytes:
- 0–5: SHA.
- 6–11: `cfg_mac`.
- 12–13: 0x0806.
- 14–15: 0x0001.
- 16–17: 0x0800.
- 18: 06.
- 19: 04.
- 20–21: 0x0002.
- 22–27: `cfg_mac`.
- 28–31: `cfg_ip`.
- 32–37: SHA.
- 38–41: SPA.
- Beats 0–9 have `tkeep` = 4'hF. Beat 10 has `tkeep` = 4'h3 and `tlast` = 1.
- `cfg_mac` and `cfg_ip` are latched on acceptance, so config changes during TX do not affect the reply in flight.

Boundaries:
- `tlast` before beat 10, or `tlast` at beat 10 with `tkeep[1:0]` ≠ 2'b11: drop, stay in RX, next frame starts clean.
- Back-to-back frames: beat counter and match flag reset on every `tlast` handshake.

## Timing
- Reset values: `rx_axis_tready` 0, `tx_axis_tvalid` 0, `tx_axis_tlast` 0, `tx_axis_tdata` 0, `tx_axis_tkeep` 0, `reply_count` 0, state RX.
- `rx_axis_tready` is registered. It rises 1 cycle after reset release, falls the cycle after an accepted `tlast`, and rises the cycle after the final TX handshake.
- Latency: the first reply beat has `tvalid` = 1 the cycle after the accepted request's `tlast` handshake. With `tx_axis_tready` held at 1, a reply takes 11 cycles.
- AXI-Stream rules: once `tvalid` is raised, `tdata`/`tkeep`/`tlast` stay stable until `tready`. No bubbles are inserted between beats of a reply.
- Reset mid-TX: all outputs return to their reset values immediately. The partial frame is abandoned; the downstream MAC FIFO is reset with the block.

## Structure
- Shared package `eth_pkg` holds:
  - constants `ETHERTYPE_ARP`, `ETHERTYPE_IPV4`, `ARP_OPER_REQ`, `ARP_OPER_REPLY`, `ARP_FRAME_BYTES` (42);
  - function `byte_lane(idx)`.
- One natural sub-module: `arp_reply_builder`, a combinational mux from TX beat index plus latched fields to `tdata`/`tkeep`/`tlast`.

## Test plan
Common config: `cfg_mac` 02:00:00:00:00:01, `cfg_ip` 192.168.1.10.
- **Basic reply**: request beats ffffffff, e000ffff, bda1684c, 01000608, 04060008, e0000100, bda1684c, 8101a8c0, 00000000, a8c00000, 00000a01 (`tkeep` 3, `tlast`) -> 11 reply beats: beat0 684ce000, beat1 0002bda1, beat9 a8c0bda1, beat10 00008101 with `tkeep` 3 and `tlast`; `reply_count` = 1.
- **IP mismatch**: same request with final word 00000b01 -> no `tx_axis_tvalid`; `rx_axis_tready` never drops.
- **TX backpressure**: `tx_axis_tready` held low 20 cycles at beat 4 -> beat 4 held stable; `rx_axis_tready` = 0 throughout; all 11 beats correct.
- **Bad frame, then short frame**: `tuser` = 1 on `tlast`, then a frame with `tlast` at beat 5 -> no reply to either; a following valid request is answered.
- **Padded request**: request padded to 60 bytes (15 beats) -> single correct reply; `reply_count` wraps from 0xFFFF to 0 when preloaded.
- **Reset mid-TX**: `resetn` low at reply beat 6 -> `tvalid` = 0 in the same cycle; after release, the next request is answered correctly.

Source files
------------

// File: rtl/eth_pkg.sv
// Ethernet/ARP constants and byte-order helpers shared by the ARP responder.
// Multi-byte fields travel MSB-first; wire order puts the first byte in the lowest lane.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_ARP   = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
    localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
    localparam logic [15:0] ARP_OPER_REQ    = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY  = 16'h0002;
    localparam logic [7:0]  ARP_HLEN        = 8'd6;
    localparam logic [7:0]  ARP_PLEN        = 8'd4;
    localparam int          ARP_FRAME_BYTES = 42;
    localparam logic [3:0]  ARP_LAST_BEAT   = 4'((ARP_FRAME_BYTES - 1) / 4);
    localparam logic [3:0]  RX_BEAT_MAX     = 4'd11;

    typedef enum logic [0:0] {
        ST_RX = 1'b0,
        ST_TX = 1'b1
    } arp_state_t;

    function automatic logic [1:0] byte_lane(input int unsigned idx);
        return idx[1:0];
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] data, input int unsigned idx);
        return data[{byte_lane(idx), 3'b000} +: 8];
    endfunction

    function automatic logic [15:0] wire16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] wire32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [47:0] wire48(input logic [47:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24], v[39:32], v[47:40]};
    endfunction

endpackage

// File: rtl/arp_reply_builder.sv
// Combinational ARP reply generator: selects one 32-bit beat of the 42-byte reply.
// All field inputs are already in wire order (first byte in bits [7:0]).
module arp_reply_builder
    import eth_pkg::*;
(
    input  logic [3:0]  beat,
    input  logic [47:0] sha_wire,
    input  logic [31:0] spa_wire,
    input  logic [47:0] mac_wire,
    input  logic [31:0] ip_wire,
    output logic [31:0] tdata,
    output logic [3:0]  tkeep,
    output logic        tlast
);

    logic [511:0] frame_s;

    // Lay out the reply bytes, padded with zeros to 16 beats, and pick the requested beat.
    always_comb begin
        frame_s            = '0;
        frame_s[0   +: 48] = sha_wire;
        frame_s[48  +: 48] = mac_wire;
        frame_s[96  +: 16] = wire16(ETHERTYPE_ARP);
        frame_s[112 +: 16] = wire16(ARP_HTYPE_ETH);
        frame_s[128 +: 16] = wire16(ETHERTYPE_IPV4);
        frame_s[144 +: 8]  = ARP_HLEN;
        frame_s[152 +: 8]  = ARP_PLEN;
        frame_s[160 +: 16] = wire16(ARP_OPER_REPLY);
        frame_s[176 +: 48] = mac_wire;
        frame_s[224 +: 32] = ip_wire;
        frame_s[256 +: 48] = sha_wire;
        frame_s[304 +: 32] = spa_wire;
        tdata              = frame_s[{beat, 5'b00000} +: 32];
        if (beat == ARP_LAST_BEAT) begin
            tkeep = 4'h3;
            tlast = 1'b1;
        end else begin
            tkeep = 4'hF;
            tlast = 1'b0;
        end
    end

endmodule

// File: rtl/axis_arp_responder.sv
// Hardware ARP responder: parses request frames on rx_axis and answers matching
// requests for cfg_ip with an 11-beat reply on tx_axis.
module axis_arp_responder
    import eth_pkg::*;
#(
    parameter int REPLY_COUNT_W = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [47:0]              cfg_mac,
    input  logic [31:0]              cfg_ip,
    input  logic [31:0]              rx_axis_tdata,
    input  logic [3:0]               rx_axis_tkeep,
    input  logic                     rx_axis_tvalid,
    output logic                     rx_axis_tready,
    input  logic                     rx_axis_tlast,
    input  logic                     rx_axis_tuser,
    output logic [31:0]              tx_axis_tdata,
    output logic [3:0]               tx_axis_tkeep,
    output logic                     tx_axis_tvalid,
    input  logic                     tx_axis_tready,
    output logic                     tx_axis_tlast,
    output logic                     tx_axis_tuser,
    output logic [REPLY_COUNT_W-1:0] reply_count
);

    arp_state_t               state_r;
    logic                     rx_tready_r;
    logic [3:0]               rx_beat_r;
    logic                     match_r;
    logic [1:0]               dst_r;
    logic [47:0]              sha_wire_r;
    logic [31:0]              spa_wire_r;
    logic [15:0]              tpa_hi_wire_r;
    logic [47:0]              mac_r;
    logic [31:0]              ip_r;
    logic [3:0]               tx_beat_r;
    logic [31:0]              tx_tdata_r;
    logic [3:0]               tx_tkeep_r;
    logic                     tx_tvalid_r;
    logic                     tx_tlast_r;
    logic [REPLY_COUNT_W-1:0] reply_count_r;

    logic [47:0] cfg_mac_wire_s;
    logic        rx_hs_s;
    logic        beat_ok_s;
    logic        match_next_s;
    logic        accept_s;
    logic [3:0]  bld_beat_s;
    logic [47:0] bld_mac_s;
    logic [31:0] bld_ip_s;
    logic [31:0] bld_tdata_s;
    logic [3:0]  bld_tkeep_s;
    logic        bld_tlast_s;

    assign cfg_mac_wire_s = wire48(cfg_mac);
    assign rx_hs_s        = rx_axis_tvalid & rx_tready_r;
    assign match_next_s   = match_r & beat_ok_s;
    assign accept_s       = rx_hs_s & rx_axis_tlast & match_next_s & ~rx_axis_tuser
                            & (rx_beat_r >= ARP_LAST_BEAT);

    // Per-beat header check; beats outside the checked fields always pass.
    always_comb begin
        beat_ok_s = 1'b1;
        case (rx_beat_r)
            4'd1:    beat_ok_s = (dst_r[1] & (rx_axis_tdata[15:0] == 16'hFFFF)) |
                                 (dst_r[0] & (rx_axis_tdata[15:0] == cfg_mac_wire_s[47:32]));
            4'd3:    beat_ok_s = (rx_axis_tdata == {wire16(ARP_HTYPE_ETH), wire16(ETHERTYPE_ARP)});
            4'd4:    beat_ok_s = (rx_axis_tdata[15:0] == wire16(ETHERTYPE_IPV4)) &
                                 (lane_byte(rx_axis_tdata, 18) == ARP_HLEN) &
                                 (lane_byte(rx_axis_tdata, 19) == ARP_PLEN);
            4'd5:    beat_ok_s = (rx_axis_tdata[15:0] == wire16(ARP_OPER_REQ));
            4'd10:   beat_ok_s = (rx_axis_tkeep[1:0] == 2'b11) &
                                 ({rx_axis_tdata[15:0], tpa_hi_wire_r} == wire32(cfg_ip));
            default: beat_ok_s = 1'b1;
        endcase
    end

    // While receiving, the builder previews beat 0 with live config so it can load on acceptance.
    always_comb begin
        if (state_r == ST_TX) begin
            bld_beat_s = tx_beat_r + 4'd1;
            bld_mac_s  = mac_r;
            bld_ip_s   = ip_r;
        end else begin
            bld_beat_s = 4'd0;
            bld_mac_s  = cfg_mac;
            bld_ip_s   = cfg_ip;
        end
    end

    arp_reply_builder u_builder (
        .beat     (bld_beat_s),
        .sha_wire (sha_wire_r),
        .spa_wire (spa_wire_r),
        .mac_wire (wire48(bld_mac_s)),
        .ip_wire  (wire32(bld_ip_s)),
        .tdata    (bld_tdata_s),
        .tkeep    (bld_tkeep_s),
        .tlast    (bld_tlast_s)
    );

    // Receive/transmit FSM with all stream outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_RX;
            rx_tready_r   <= 1'b0;
            rx_beat_r     <= 4'd0;
            match_r       <= 1'b1;
            dst_r         <= 2'b00;
            sha_wire_r    <= 48'd0;
            spa_wire_r    <= 32'd0;
            tpa_hi_wire_r <= 16'd0;
            mac_r         <= 48'd0;
            ip_r          <= 32'd0;
            tx_beat_r     <= 4'd0;
            tx_tdata_r    <= 32'd0;
            tx_tkeep_r    <= 4'd0;
            tx_tvalid_r   <= 1'b0;
            tx_tlast_r    <= 1'b0;
            reply_count_r <= '0;
        end else begin
            case (state_r)
                ST_RX: begin
                    rx_tready_r <= 1'b1;
                    if (rx_hs_s) begin
                        case (rx_beat_r)
                            4'd0:    dst_r <= {rx_axis_tdata == 32'hFFFF_FFFF,
                                               rx_axis_tdata == cfg_mac_wire_s[31:0]};
                            4'd5:    sha_wire_r[15:0]  <= rx_axis_tdata[31:16];
                            4'd6:    sha_wire_r[47:16] <= rx_axis_tdata;
                            4'd7:    spa_wire_r        <= rx_axis_tdata;
                            4'd9:    tpa_hi_wire_r     <= rx_axis_tdata[31:16];
                            default: ;
                        endcase
                        if (rx_axis_tlast) begin
                            rx_beat_r <= 4'd0;
                            match_r   <= 1'b1;
                            if (accept_s) begin
                                state_r     <= ST_TX;
                                rx_tready_r <= 1'b0;
                                mac_r       <= cfg_mac;
                                ip_r        <= cfg_ip;
                                tx_beat_r   <= 4'd0;
                                tx_tvalid_r <= 1'b1;
                                tx_tdata_r  <= bld_tdata_s;
                                tx_tkeep_r  <= bld_tkeep_s;
                                tx_tlast_r  <= bld_tlast_s;
                            end
                        end else begin
                            match_r <= match_next_s;
                            if (rx_beat_r != RX_BEAT_MAX) begin
                                rx_beat_r <= rx_beat_r + 4'd1;
                            end
                        end
                    end
                end
                ST_TX: begin
                    rx_tready_r <= 1'b0;
                    if (tx_axis_tready) begin
                        if (tx_beat_r == ARP_LAST_BEAT) begin
                            state_r       <= ST_RX;
                            rx_tready_r   <= 1'b1;
                            tx_tvalid_r   <= 1'b0;
                            tx_tlast_r    <= 1'b0;
                            tx_tdata_r    <= 32'd0;
                            tx_tkeep_r    <= 4'd0;
                            reply_count_r <= reply_count_r + REPLY_COUNT_W'(1);
                        end else begin
                            tx_beat_r  <= tx_beat_r + 4'd1;
                            tx_tdata_r <= bld_tdata_s;
                            tx_tkeep_r <= bld_tkeep_s;
                            tx_tlast_r <= bld_tlast_s;
                        end
                    end
                end
                default: state_r <= ST_RX;
            endcase
        end
    end

    assign rx_axis_tready = rx_tready_r;
    assign tx_axis_tdata  = tx_tdata_r;
    assign tx_axis_tkeep  = tx_tkeep_r;
    assign tx_axis_tvalid = tx_tvalid_r;
    assign tx_axis_tlast  = tx_tlast_r;
    assign tx_axis_tuser  = 1'b0;
    assign reply_count    = reply_count_r;

endmodule

// File: tb/tb_axis_arp_responder.sv
// Directed scoreboard bench for axis_arp_responder.
module tb_axis_arp_responder;

    localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
    localparam logic [31:0] IP  = 32'hC0_A8_01_0A;
    localparam logic [47:0] SHA = 48'h00_E0_4C_68_A1_BD;
    localparam logic [31:0] SPA = 32'hC0_A8_01_81;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [47:0] cfg_mac;
    logic [31:0] cfg_ip;
    logic [31:0] rx_tdata;
    logic [3:0]  rx_tkeep;
    logic        rx_tvalid;
    logic        rx_tready;
    logic        rx_tlast;
    logic        rx_tuser;
    logic [31:0] tx_tdata;
    logic [3:0]  tx_tkeep;
    logic        tx_tvalid;
    logic        tx_tready;
    logic        tx_tlast;
    logic        tx_tuser;
    logic [15:0] reply_count;

    int          checks = 0;
    int          failures = 0;
    int          rx_stalls;
    beat_t       exp_q[$];
    logic [31:0] fw [0:15];
    int          flen;
    logic [3:0]  last_keep;
    logic [31:0] obs [0:10];

    always #5 clk = ~clk;

    axis_arp_responder #(.REPLY_COUNT_W(16)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cfg_mac        (cfg_mac),
        .cfg_ip         (cfg_ip),
        .rx_axis_tdata  (rx_tdata),
        .rx_axis_tkeep  (rx_tkeep),
        .rx_axis_tvalid (rx_tvalid),
        .rx_axis_tready (rx_tready),
        .rx_axis_tlast  (rx_tlast),
        .rx_axis_tuser  (rx_tuser),
        .tx_axis_tdata  (tx_tdata),
        .tx_axis_tkeep  (tx_tkeep),
        .tx_axis_tvalid (tx_tvalid),
        .tx_axis_tready (tx_tready),
        .tx_axis_tlast  (tx_tlast),
        .tx_axis_tuser  (tx_tuser),
        .reply_count    (reply_count)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic make_request(input logic [31:0] last_word);
        fw[0]  = 32'hFFFF_FFFF; fw[1]  = 32'hE000_FFFF; fw[2]  = 32'hBDA1_684C;
        fw[3]  = 32'h0100_0608; fw[4]  = 32'h0406_0008; fw[5]  = 32'hE000_0100;
        fw[6]  = 32'hBDA1_684C; fw[7]  = 32'h8101_A8C0; fw[8]  = 32'h0000_0000;
        fw[9]  = 32'hA8C0_0000; fw[10] = last_word;
        for (int i = 11; i < 16; i++) fw[i] = 32'd0;
        flen      = 11;
        last_keep = 4'h3;
    endtask

    // Reference reply built byte by byte from the ARP reply layout.
    task automatic push_reply(input logic [47:0] mac, input logic [31:0] ip,
                              input logic [47:0] sha, input logic [31:0] spa);
        logic [7:0] rb [0:43];
        beat_t      b;
        for (int k = 0; k < 6; k++) begin
            rb[k]      = sha[8*(5-k) +: 8];
            rb[6 + k]  = mac[8*(5-k) +: 8];
            rb[22 + k] = mac[8*(5-k) +: 8];
            rb[32 + k] = sha[8*(5-k) +: 8];
        end
        rb[12] = 8'h08; rb[13] = 8'h06; rb[14] = 8'h00; rb[15] = 8'h01;
        rb[16] = 8'h08; rb[17] = 8'h00; rb[18] = 8'h06; rb[19] = 8'h04;
        rb[20] = 8'h00; rb[21] = 8'h02;
        for (int k = 0; k < 4; k++) begin
            rb[28 + k] = ip[8*(3-k) +: 8];
            rb[38 + k] = spa[8*(3-k) +: 8];
        end
        rb[42] = 8'h00; rb[43] = 8'h00;
        for (int j = 0; j < 11; j++) begin
            b.d = {rb[4*j+3], rb[4*j+2], rb[4*j+1], rb[4*j]};
            b.k = (j == 10) ? 4'h3 : 4'hF;
            b.l = (j == 10);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_frame(input logic bad);
        int n;
        rx_stalls = 0;
        for (int i = 0; i < flen; i++) begin
            rx_tdata  = fw[i];
            rx_tkeep  = (i == flen - 1) ? last_keep : 4'hF;
            rx_tlast  = (i == flen - 1);
            rx_tuser  = (i == flen - 1) & bad;
            rx_tvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!rx_tready && n < 100) begin
                rx_stalls++;
                n++;
                @(negedge clk);
            end
            if (n >= 100) check("rx_ready_timeout", 64'(n), 64'd0);
            tick();
        end
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        rx_tuser  = 1'b0;
    endtask

    task automatic collect_reply(input int stall_beat, input int stall_len, input int abort_beat);
        int    got = 0;
        int    cyc = 0;
        int    stall_left = stall_len;
        beat_t e;
        while (got < 11 && cyc < 300) begin
            if (got == abort_beat) return;
            tx_tready = !(got == stall_beat && stall_left > 0);
            @(negedge clk);
            if (cyc == 0) check("reply_latency", 64'(tx_tvalid), 64'd1);
            if (tx_tvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(got), 64'd11);
                    break;
                end
                e = exp_q[0];
                check("rx_ready_in_tx", 64'(rx_tready), 64'd0);
                check("tx_tdata", 64'(tx_tdata), 64'(e.d));
                check("tx_tkeep", 64'(tx_tkeep), 64'(e.k));
                check("tx_tlast", 64'(tx_tlast), 64'(e.l));
                if (tx_tready) begin
                    obs[got] = tx_tdata;
                    void'(exp_q.pop_front());
                    got++;
                end else begin
                    stall_left--;
                end
            end
            tick();
            cyc++;
        end
        tx_tready = 1'b1;
        if (got < 11) check("reply_timeout", 64'(got), 64'd11);
        @(negedge clk);
        check("tvalid_after_reply", 64'(tx_tvalid), 64'd0);
        check("rx_ready_after_reply", 64'(rx_tready), 64'd1);
        tick();
    endtask

    task automatic expect_none(input string tag, input logic [15:0] count_exp);
        logic saw_valid = 1'b0;
        logic saw_stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_tvalid) saw_valid = 1'b1;
            if (!rx_tready) saw_stall = 1'b1;
            tick();
        end
        check({tag, "_no_tvalid"}, 64'(saw_valid), 64'd0);
        check({tag, "_rx_ready_held"}, 64'(saw_stall), 64'd0);
        check({tag, "_count"}, 64'(reply_count), 64'(count_exp));
    endtask

    initial begin
        resetn    = 1'b0;
        cfg_mac   = MAC;
        cfg_ip    = IP;
        rx_tdata  = 32'd0;
        rx_tkeep  = 4'd0;
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        rx_tuser  = 1'b0;
        tx_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_tready", 64'(rx_tready), 64'd0);
        check("rst_tx_tvalid", 64'(tx_tvalid), 64'd0);
        check("rst_tx_tlast", 64'(tx_tlast), 64'd0);
        check("rst_tx_tdata", 64'(tx_tdata), 64'd0);
        check("rst_tx_tkeep", 64'(tx_tkeep), 64'd0);
        check("rst_reply_count", 64'(reply_count), 64'd0);
        check("tx_tuser", 64'(tx_tuser), 64'd0);
        tick();
        resetn = 1'b1;
        @(negedge clk);
        check("rx_ready_before_rise", 64'(rx_tready), 64'd0);
        tick();
        @(negedge clk);
        check("rx_ready_after_release", 64'(rx_tready), 64'd1);
        tick();

        // Basic reply, with spot checks against hand-decoded beats.
        make_request(32'h0000_0A01);
        push_reply(MAC, IP, SHA, SPA);
        send_frame(1'b0);
        collect_reply(-1, 0, -1);
        check("basic_beat0", 64'(obs[0]), 64'h684C_E000);
        check("basic_beat1", 64'(obs[1]), 64'h0002_BDA1);
        check("basic_beat9", 64'(obs[9]), 64'hA8C0_BDA1);
        check("basic_beat10", 64'(obs[10]), 64'h0000_8101);
        check("basic_count", 64'(reply_count), 64'd1);

        // Target IP mismatch.
        make_request(32'h0000_0B01);
        send_frame(1'b0);
        check("ipmis_rx_stalls", 64'(rx_stalls), 64'd0);
        expect_none("ipmis", 16'd1);

        // Backpressure at reply beat 4 for 20 cycles.
        make_request(32'h0000_0A01);
        push_reply(MAC, IP, SHA, SPA);
        send_frame(1'b0);
        collect_reply(4, 20, -1);
        check("bp_count", 64'(reply_count), 64'd2);

        // Bad frame, short frame, short last beat, then a good request.
        make_request(32'h0000_0A01);
        send_frame(1'b1);
        expect_none("badframe", 16'd2);
        make_request(32'h0000_0A01);
        flen = 6;
        last_keep = 4'hF;
        send_frame(1'b0);
        expect_none("short", 16'd2);
        make_request(32'h0000_0A01);
        last_keep = 4'h1;
        send_frame(1'b0);
        expect_none("keep_short", 16'd2);
        make_request(32'h0000_0A01);
        push_reply(MAC, IP, SHA, SPA);
        send_frame(1'b0);
        collect_reply(-1, 0, -1);
        check("recover_count", 64'(reply_count), 64'd3);

        // Padded request with the counter preloaded to wrap.
        force dut.reply_count_r = 16'hFFFF;
        @(negedge clk);
        release dut.reply_count_r;
        tick();
        check("preload_count", 64'(reply_count), 64'hFFFF);
        make_request(32'h0000_0A01);
        flen = 15;
        last_keep = 4'hF;
        push_reply(MAC, IP, SHA, SPA);
        send_frame(1'b0);
        collect_reply(-1, 0, -1);
        check("wrap_count", 64'(reply_count), 64'd0);

        // Reset during reply beat 6, config changed mid-flight must not matter afterwards.
        make_request(32'h0000_0A01);
        push_reply(MAC, IP, SHA, SPA);
        send_frame(1'b0);
        collect_reply(-1, 0, 6);
        resetn = 1'b0;
        #1;
        check("midrst_tvalid", 64'(tx_tvalid), 64'd0);
        check("midrst_tlast", 64'(tx_tlast), 64'd0);
        check("midrst_tdata", 64'(tx_tdata), 64'd0);
        check("midrst_rx_tready", 64'(rx_tready), 64'd0);
        check("midrst_count", 64'(reply_count), 64'd0);
        exp_q.delete();
        tx_tready = 1'b1;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        tick();
        make_request(32'h0000_0A01);
        push_reply(MAC, IP, SHA, SPA);
        send_frame(1'b0);
        cfg_mac = 48'h02_00_00_00_00_99;
        collect_reply(-1, 0, -1);
        check("postrst_count", 64'(reply_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
